data_bus_if: RTL and testbench
==============================

# data_bus_if

Wishbone master bridge sitting directly downstream of the `mem` stage. It turns the stage's single-cycle data-memory request (`ce`, `we`, `sel`, `addr`, `data`) into a registered Wishbone B4 classic cycle and returns load data to `mem`. It holds the pipeline through `stallreq` until the slave acknowledges, and cooperates with `ctrl` stall/flush so that a completed access is never re-issued.

## Interface
Parameters:
- `STALL_IDX`, default 4: bit of `stall_i` that corresponds to the MEM stage.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on rising `clk`.
- `stall_i`  in  6  pipeline stall vector from `ctrl`.
- `flush_i`  in  1  pipeline flush from `ctrl`.
- `cpu_ce_i`  in  1  access request (`mem_ce_o` of `mem`).
- `cpu_we_i`  in  1  1 = store, 0 = load.
- `cpu_addr_i`  in  32  byte address, already word-aligned by `mem` for LWL/LWR/SWL/SWR.
- `cpu_sel_i`  in  4  byte lanes, bit 3 = bits 31:24 (big-endian lane order).
- `cpu_data_i`  in  32  store data, already lane-replicated.
- `cpu_data_o`  out  32  load data back to `mem` (`mem_data_i`).
- `stallreq`  out  1  request to `ctrl` to freeze the pipeline.
- `wb_adr_o`  out  32  Wishbone address.
- `wb_dat_o`  out  32  Wishbone write data.
- `wb_we_o`  out  1  Wishbone write enable.
- `wb_sel_o`  out  4  Wishbone byte select.
- `wb_stb_o`  out  1  Wishbone strobe.
- `wb_cyc_o`  out  1  Wishbone cycle.
- `wb_dat_i`  in  32  Wishbone read data.
- `wb_ack_i`  in  1  Wishbone acknowledge.

## Operation
- States: IDLE, BUSY, WAIT_STALL. Reset (`rst`=0) enters IDLE and clears all registered outputs and the read buffer `rd_buf` to 0. `wb_*_o` and `rd_buf` are registered. `cpu_data_o` and `stallreq` are combinational from state and inputs.
- IDLE:
  - If `cpu_ce_i`=1 and `flush_i`=0: register `wb_adr_o`/`wb_dat_o`/`wb_we_o`/`wb_sel_o` from the `cpu_*` inputs, set `wb_cyc_o`=`wb_stb_o`=1, go to BUSY.
  - Otherwise stay.
- BUSY:
  - `flush_i`=1 has priority. Drop `cyc`/`stb`/`we`, zero `adr`/`dat`/`sel`, clear `rd_buf`, go to IDLE. A late `wb_ack_i` for the abandoned cycle is ignored.
  - Else, if `wb_ack_i`=1: drop `cyc`/`stb`/`we`, zero `adr`/`dat`/`sel`, and set `rd_buf`←`wb_dat_i`. Go to WAIT_STALL if `stall_i[STALL_IDX]`=1, else IDLE.
  - Else hold all Wishbone outputs unchanged.
- WAIT_STALL:
  - Used when the access is done but `ctrl` still freezes MEM for another reason.
  - Go to IDLE when `stall_i[STALL_IDX]`=0. `flush_i`=1 also returns to IDLE.
  - `rd_buf` is cleared on exit.
- Combinational outputs:
  - IDLE: `stallreq` = `cpu_ce_i` & ~`flush_i`; `cpu_data_o`=0.
  - BUSY: if `wb_ack_i`=1, `stallreq`=0 and `cpu_data_o`=`wb_dat_i`; else `stallreq`=1 and `cpu_data_o`=0.
  - WAIT_STALL: `stallreq`=0; `cpu_data_o`=`rd_buf`.
- Stores return `cpu_data_o` by the same rules. `mem` ignores it for stores.
- Only one outstanding cycle. No pipelined or burst Wishbone, no error/retry inputs.

## Timing
- Request seen in IDLE at cycle 0: `stallreq`=1 during cycle 0. `wb_cyc_o`/`wb_stb_o` go high from cycle 1.
- Ack in cycle k≥1: data is valid on `cpu_data_o` and `stallreq`=0 in cycle k. `cyc`/`stb` go low from cycle k+1. Minimum access is 2 cycles (zero-wait slave acks in cycle 1).
- WAIT_STALL holds `cpu_data_o`=`rd_buf` stable for every stalled cycle. This guarantees the pipeline register after MEM captures correct data on release.
- Back-to-back accesses: after returning to IDLE, a new `cpu_ce_i` starts the next cycle. `cyc` is low for at least one cycle between accesses.
- `rst`=0 during BUSY aborts immediately: all outputs are 0 from the next cycle, state is IDLE.
- `wb_*_o` never change while `cyc`=1 and no ack has arrived (Wishbone hold rule).

## Test plan
- Zero-wait load: addr 0x0000_0010, `sel`=4'b1111, `we`=0; slave acks in cycle 1 with 0xDEAD_BEEF. Expect `stallreq`=1,0 in cycles 0,1; `cpu_data_o`=0xDEAD_BEEF in cycle 1; `cyc`=0 in cycle 2.
- 3-wait store (SB): addr 0x0000_0023, `sel`=4'b0001, data 0x5A5A_5A5A; ack in cycle 4. Expect `wb_*` stable in cycles 1–4 with `we`=1; `stallreq`=1 through cycle 3, 0 in cycle 4.
- Ack while `stall_i[4]`=1: load returns 0x1234_5678 in cycle 2, and `stall_i[4]` stays high until cycle 5. Expect `cpu_data_o`=0x1234_5678 in cycles 2–5, `stallreq`=0, and no second `cyc` assertion.
- Flush mid-cycle: `flush_i`=1 in cycle 2 before any ack. Expect `cyc`/`stb`=0 in cycle 3 and state IDLE; an ack in cycle 3 produces no `cpu_data_o` change (stays 0).
- Reset mid-access: `rst`=0 in cycle 2 of a pending load. Expect all `wb_*_o`=0, `stallreq`=0 (with `cpu_ce_i`=0), and `cpu_data_o`=0 from cycle 3.
- Back-to-back: LW then SW with zero-wait slave. Expect two distinct `cyc` pulses separated by one low cycle, and correct `adr`/`sel`/`we` for each.

Source files
------------

// File: rtl/data_bus_if.sv
// rtl/data_bus_if.sv - Wishbone B4 classic master bridge between the MEM stage and the data bus
module data_bus_if #(
    parameter int STALL_IDX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic [31:0] rd_buf_q, rd_buf_d;

    logic mem_stalled;
    assign mem_stalled = stall_i[STALL_IDX];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            adr_q    <= 32'h0;
            dat_q    <= 32'h0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
        end
    end

    // Next-state logic; bus outputs only move on launch, ack, or flush.
    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        we_d     = we_q;
        sel_d    = sel_q;
        stb_d    = stb_q;
        cyc_d    = cyc_q;
        rd_buf_d = rd_buf_q;

        case (state_q)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_d   = cpu_addr_i;
                    dat_d   = cpu_data_i;
                    we_d    = cpu_we_i;
                    sel_d   = cpu_sel_i;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (flush_i || wb_ack_i) begin
                    adr_d = 32'h0;
                    dat_d = 32'h0;
                    we_d  = 1'b0;
                    sel_d = 4'h0;
                    stb_d = 1'b0;
                    cyc_d = 1'b0;
                end
                if (flush_i) begin
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end else if (wb_ack_i) begin
                    rd_buf_d = wb_dat_i;
                    state_d  = mem_stalled ? WAIT_STALL : IDLE;
                end
            end
            WAIT_STALL: begin
                if (flush_i || !mem_stalled) begin
                    rd_buf_d = 32'h0;
                    state_d  = IDLE;
                end
            end
            default: begin
                adr_d    = 32'h0;
                dat_d    = 32'h0;
                we_d     = 1'b0;
                sel_d    = 4'h0;
                stb_d    = 1'b0;
                cyc_d    = 1'b0;
                rd_buf_d = 32'h0;
                state_d  = IDLE;
            end
        endcase
    end

    // Ack releases the pipeline in the same cycle with bus data passed straight through.
    always_comb begin
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;
        case (state_q)
            IDLE: begin
                stallreq = cpu_ce_i & ~flush_i;
            end
            BUSY: begin
                if (wb_ack_i) begin
                    cpu_data_o = wb_dat_i;
                end else begin
                    stallreq = 1'b1;
                end
            end
            WAIT_STALL: begin
                cpu_data_o = rd_buf_q;
            end
            default: begin
                stallreq   = 1'b0;
                cpu_data_o = 32'h0;
            end
        endcase
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;

endmodule

// File: tb/tb_data_bus_if.sv
// tb/tb_data_bus_if.sv - directed self-checking bench for data_bus_if
module tb_data_bus_if;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    int total = 0;
    int bad   = 0;

    data_bus_if #(.STALL_IDX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_we_i   (cpu_we_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_sel_i  (cpu_sel_i),
        .cpu_data_i (cpu_data_i),
        .cpu_data_o (cpu_data_o),
        .stallreq   (stallreq),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_stb_o   (wb_stb_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each cycle: inputs change 1 time unit after the rising edge, outputs sampled at mid-cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data);
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = data;
    endtask

    task automatic chk_bus(input string tag, input logic cyc, input logic [31:0] adr,
                           input logic [31:0] dat, input logic we, input logic [3:0] sel);
        chk({tag, "_cyc"}, {31'h0, wb_cyc_o}, {31'h0, cyc});
        chk({tag, "_stb"}, {31'h0, wb_stb_o}, {31'h0, cyc});
        chk({tag, "_adr"}, wb_adr_o, adr);
        chk({tag, "_dat"}, wb_dat_o, dat);
        chk({tag, "_we"},  {31'h0, wb_we_o}, {31'h0, we});
        chk({tag, "_sel"}, {28'h0, wb_sel_o}, {28'h0, sel});
    endtask

    task automatic chk_cpu(input string tag, input logic sr, input logic [31:0] d);
        chk({tag, "_stallreq"}, {31'h0, stallreq}, {31'h0, sr});
        chk({tag, "_cpu_data"}, cpu_data_o, d);
    endtask

    initial begin
        rst        = 1'b0;
        stall_i    = 6'h0;
        flush_i    = 1'b0;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_sel_i  = 4'h0;
        cpu_data_i = 32'h0;
        wb_dat_i   = 32'h0;
        wb_ack_i   = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        chk_bus("rst", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        chk_cpu("rst", 1'b0, 32'h0);
        next_cycle();
        rst = 1'b1;

        // Zero-wait load
        next_cycle();
        req(1'b0, 32'h0000_0010, 4'b1111, 32'h0);
        settle();
        chk_cpu("ld0_c0", 1'b1, 32'h0);
        chk({"ld0_c0_cyc"}, {31'h0, wb_cyc_o}, 32'h0);
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        settle();
        chk_bus("ld0_c1", 1'b1, 32'h0000_0010, 32'h0, 1'b0, 4'b1111);
        chk_cpu("ld0_c1", 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        settle();
        chk_bus("ld0_c2", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        chk_cpu("ld0_c2", 1'b0, 32'h0);

        // 3-wait store byte
        next_cycle();
        req(1'b1, 32'h0000_0023, 4'b0001, 32'h5A5A_5A5A);
        settle();
        chk_cpu("sb_c0", 1'b1, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            settle();
            chk_bus($sformatf("sb_c%0d", c), 1'b1, 32'h0000_0023, 32'h5A5A_5A5A, 1'b1, 4'b0001);
            chk_cpu($sformatf("sb_c%0d", c), 1'b1, 32'h0);
        end
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_0077;
        settle();
        chk_bus("sb_c4", 1'b1, 32'h0000_0023, 32'h5A5A_5A5A, 1'b1, 4'b0001);
        chk_cpu("sb_c4", 1'b0, 32'h0000_0077);
        next_cycle();
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        settle();
        chk_bus("sb_c5", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);

        // Ack while MEM is stalled by ctrl
        next_cycle();
        req(1'b0, 32'h0000_0040, 4'b1111, 32'h0);
        next_cycle();
        settle();
        chk_cpu("ws_c1", 1'b1, 32'h0);
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        stall_i  = 6'b01_0000;
        settle();
        chk_cpu("ws_c2", 1'b0, 32'h1234_5678);
        for (int c = 3; c <= 5; c++) begin
            next_cycle();
            wb_ack_i = 1'b0;
            wb_dat_i = 32'hFFFF_FFFF;
            settle();
            chk_cpu($sformatf("ws_c%0d", c), 1'b0, 32'h1234_5678);
            chk($sformatf("ws_c%0d_cyc", c), {31'h0, wb_cyc_o}, 32'h0);
        end
        next_cycle();
        stall_i  = 6'h0;
        cpu_ce_i = 1'b0;
        settle();
        chk("ws_c6_cyc", {31'h0, wb_cyc_o}, 32'h0);
        next_cycle();
        wb_dat_i = 32'h0;
        settle();
        chk_cpu("ws_c7", 1'b0, 32'h0);
        chk("ws_c7_cyc", {31'h0, wb_cyc_o}, 32'h0);

        // Flush before ack; late ack ignored
        next_cycle();
        req(1'b0, 32'h0000_0080, 4'b1111, 32'h0);
        next_cycle();
        settle();
        chk("fl_c1_cyc", {31'h0, wb_cyc_o}, 32'h1);
        next_cycle();
        flush_i = 1'b1;
        settle();
        chk_cpu("fl_c2", 1'b1, 32'h0);
        next_cycle();
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hAAAA_5555;
        settle();
        chk_bus("fl_c3", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        chk_cpu("fl_c3", 1'b0, 32'h0);
        next_cycle();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        // Flush in IDLE suppresses a new request
        req(1'b0, 32'h0000_0090, 4'b1111, 32'h0);
        flush_i = 1'b1;
        settle();
        chk_cpu("fli_c0", 1'b0, 32'h0);
        next_cycle();
        flush_i  = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk("fli_c1_cyc", {31'h0, wb_cyc_o}, 32'h0);

        // Reset during a pending load
        next_cycle();
        req(1'b0, 32'h0000_00C0, 4'b0011, 32'h0);
        next_cycle();
        settle();
        chk_bus("rm_c1", 1'b1, 32'h0000_00C0, 32'h0, 1'b0, 4'b0011);
        next_cycle();
        rst      = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk_cpu("rm_c2", 1'b1, 32'h0);
        next_cycle();
        rst = 1'b1;
        settle();
        chk_bus("rm_c3", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        chk_cpu("rm_c3", 1'b0, 32'h0);

        // Back-to-back LW then SW, zero-wait slave
        next_cycle();
        req(1'b0, 32'h0000_0100, 4'b1111, 32'h0);
        settle();
        chk_cpu("bb_c0", 1'b1, 32'h0);
        next_cycle();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0102_0304;
        settle();
        chk_bus("bb_c1", 1'b1, 32'h0000_0100, 32'h0, 1'b0, 4'b1111);
        chk_cpu("bb_c1", 1'b0, 32'h0102_0304);
        next_cycle();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        req(1'b1, 32'h0000_0104, 4'b1100, 32'hCAFE_F00D);
        settle();
        chk("bb_c2_cyc", {31'h0, wb_cyc_o}, 32'h0);
        chk_cpu("bb_c2", 1'b1, 32'h0);
        next_cycle();
        wb_ack_i = 1'b1;
        settle();
        chk_bus("bb_c3", 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 1'b1, 4'b1100);
        chk_cpu("bb_c3", 1'b0, 32'h0);
        next_cycle();
        wb_ack_i = 1'b0;
        cpu_ce_i = 1'b0;
        settle();
        chk_bus("bb_c4", 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
